// File: rtl/if_fetch.sv
// Instruction fetch stage: assembles 32-bit instructions from four byte
// reads of an 8-bit synchronous memory and presents them to decode.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_i,
  output logic        mem_req_o,
  output logic [31:0] mem_addr_o,
  input  logic        mem_busy_i,
  input  logic [7:0]  mem_rdata_i,
  output logic [31:0] if_pc_o,
  output logic [31:0] if_inst_o,
  output logic        if_valid_o
);

  typedef enum logic {FETCH, DONE} state_e;

  state_e          state_q, state_d;
  logic [31:0]     pc_q, pc_d;
  logic [2:0]      issue_q, issue_d;
  logic [2:0]      recv_q, recv_d;
  logic            pend_q, pend_d;
  logic [3:0][7:0] bytes_q, bytes_d;
  logic [31:0]     opc_q, opc_d;
  logic [31:0]     inst_q, inst_d;
  logic            valid_q, valid_d;
  logic            req;
  logic            accept;

  // Requests are suppressed in reset and in the redirect cycle.
  assign req = rst && (state_q == FETCH) && (issue_q < 3'd4)
               && !branch_flag_i;
  assign accept = req && !mem_busy_i;

  assign mem_req_o  = req;
  assign mem_addr_o = rst ? pc_q + {29'b0, issue_q} : 32'h0;
  assign if_pc_o    = opc_q;
  assign if_inst_o  = inst_q;
  assign if_valid_o = valid_q;

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    issue_d = issue_q;
    recv_d  = recv_q;
    pend_d  = pend_q;
    bytes_d = bytes_q;
    opc_d   = opc_q;
    inst_d  = inst_q;
    valid_d = valid_q;
    if (branch_flag_i) begin
      // Redirect drops any in-flight byte by clearing pend.
      pc_d    = {branch_target_i[31:2], 2'b00};
      state_d = FETCH;
      issue_d = 3'd0;
      recv_d  = 3'd0;
      pend_d  = 1'b0;
      valid_d = 1'b0;
    end else begin
      unique case (state_q)
        FETCH: begin
          pend_d = accept;
          if (accept) issue_d = issue_q + 3'd1;
          if (pend_q) begin
            bytes_d[recv_q[1:0]] = mem_rdata_i;
            recv_d = recv_q + 3'd1;
            if (recv_q == 3'd3) begin
              inst_d  = {mem_rdata_i, bytes_q[2],
                         bytes_q[1], bytes_q[0]};
              opc_d   = pc_q;
              valid_d = 1'b1;
              state_d = DONE;
            end
          end
        end
        DONE: begin
          pend_d = 1'b0;
          if (!stall_i) begin
            valid_d = 1'b0;
            pc_d    = pc_q + 32'd4;
            issue_d = 3'd0;
            recv_d  = 3'd0;
            state_d = FETCH;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      issue_q <= 3'd0;
      recv_q  <= 3'd0;
      pend_q  <= 1'b0;
      bytes_q <= '0;
      opc_q   <= 32'h0;
      inst_q  <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
      pend_q  <= pend_d;
      bytes_q <= bytes_d;
      opc_q   <= opc_d;
      inst_q  <= inst_d;
      valid_q <= valid_d;
    end
  end

endmodule

// File: tb/tb_if_fetch.sv
// Bench for if_fetch: directed scenarios plus randomized traffic
// checked against a fetch-count reference model.
module tb_if_fetch;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_target_i = 32'h0;
  logic        mem_req_o;
  logic [31:0] mem_addr_o;
  logic        mem_busy_i = 1'b0;
  logic [7:0]  mem_rdata_i;
  logic [31:0] if_pc_o;
  logic [31:0] if_inst_o;
  logic        if_valid_o;

  logic [7:0] mem [0:4095];
  int checks = 0;
  int passes = 0;

  if_fetch #(.RESET_PC(32'h0)) dut (
    .clk(clk), .rst(rst), .stall_i(stall_i),
    .branch_flag_i(branch_flag_i),
    .branch_target_i(branch_target_i),
    .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
    .mem_busy_i(mem_busy_i), .mem_rdata_i(mem_rdata_i),
    .if_pc_o(if_pc_o), .if_inst_o(if_inst_o),
    .if_valid_o(if_valid_o)
  );

  always #5 clk = ~clk;

  // Byte memory: data only for accepted requests, garbage otherwise.
  always @(posedge clk) begin
    if (rst && mem_req_o && !mem_busy_i)
      mem_rdata_i <= mem[mem_addr_o[11:0]];
    else
      mem_rdata_i <= 8'($urandom);
  end

  function automatic logic [31:0] word(input logic [31:0] a);
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = mem[12'(a + 32'(i))];
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    stall_i = 1'b0;
    branch_flag_i = 1'b0;
    mem_busy_i = 1'b0;
    step();
    step();
    rst = 1'b1;
    #1;
  endtask

  task automatic wait_valid(input int limit, output int n);
    n = 0;
    while (!if_valid_o && n < limit) begin
      step();
      n++;
    end
  endtask

  task automatic load_nop();
    mem[0] = 8'h13;
    mem[1] = 8'h00;
    mem[2] = 8'h00;
    mem[3] = 8'h00;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o} !== 98'b0)
      $display("FAIL reset_out: req=%b addr=%h v=%b pc=%h inst=%h want 0",
               mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o);
    else passes++;
    step();
    step();
    checks++;
    if ({mem_req_o, if_valid_o} !== 2'b0)
      $display("FAIL reset_hold: req=%b v=%b want 0 0",
               mem_req_o, if_valid_o);
    else passes++;
  endtask

  task automatic test_basic();
    load_nop();
    do_reset();
    for (int c = 0; c < 4; c++) begin
      checks++;
      if ({mem_req_o, mem_addr_o} !== {1'b1, 32'(c)})
        $display("FAIL basic_issue c%0d: req=%b addr=%h want 1 %h",
                 c, mem_req_o, mem_addr_o, c);
      else passes++;
      step();
    end
    checks++;
    if ({mem_req_o, if_valid_o} !== 2'b00)
      $display("FAIL basic_c4: req=%b v=%b want 0 0",
               mem_req_o, if_valid_o);
    else passes++;
    step();
    checks++;
    if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, 32'h13})
      $display("FAIL basic_c5: v=%b pc=%h inst=%h want 1 0 00000013",
               if_valid_o, if_pc_o, if_inst_o);
    else passes++;
    step();
    checks++;
    if ({if_valid_o, mem_req_o, mem_addr_o} !== {2'b01, 32'h4})
      $display("FAIL basic_c6: v=%b req=%b addr=%h want 0 1 4",
               if_valid_o, mem_req_o, mem_addr_o);
    else passes++;
  endtask

  task automatic test_busy();
    load_nop();
    do_reset();
    step();
    step();
    mem_busy_i = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h2})
      $display("FAIL busy_c2: req=%b addr=%h want 1 2",
               mem_req_o, mem_addr_o);
    else passes++;
    step();
    mem_busy_i = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h2})
      $display("FAIL busy_c3: req=%b addr=%h want 1 2",
               mem_req_o, mem_addr_o);
    else passes++;
    step();
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h3})
      $display("FAIL busy_c4: req=%b addr=%h want 1 3",
               mem_req_o, mem_addr_o);
    else passes++;
    step();
    checks++;
    if (if_valid_o !== 1'b0)
      $display("FAIL busy_c5: v=%b want 0", if_valid_o);
    else passes++;
    step();
    checks++;
    if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, 32'h13})
      $display("FAIL busy_c6: v=%b pc=%h inst=%h want 1 0 00000013",
               if_valid_o, if_pc_o, if_inst_o);
    else passes++;
  endtask

  task automatic test_stall();
    int n;
    load_nop();
    for (int i = 4; i < 8; i++) mem[i] = 8'($urandom);
    do_reset();
    for (int c = 0; c < 5; c++) step();
    stall_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({if_valid_o, if_pc_o, if_inst_o, mem_req_o}
          !== {1'b1, 32'h0, 32'h13, 1'b0})
        $display("FAIL stall_hold %0d: v=%b pc=%h inst=%h req=%b",
                 i, if_valid_o, if_pc_o, if_inst_o, mem_req_o);
      else passes++;
    end
    stall_i = 1'b0;
    step();
    checks++;
    if ({if_valid_o, mem_req_o, mem_addr_o} !== {2'b01, 32'h4})
      $display("FAIL stall_release: v=%b req=%b addr=%h want 0 1 4",
               if_valid_o, mem_req_o, mem_addr_o);
    else passes++;
    wait_valid(20, n);
    checks++;
    if ({if_valid_o, if_pc_o, if_inst_o, 32'(n)}
        !== {1'b1, 32'h4, word(32'h4), 32'd5})
      $display("FAIL stall_next: v=%b pc=%h inst=%h cyc=%0d want 1 4 %h 5",
               if_valid_o, if_pc_o, if_inst_o, n, word(32'h4));
    else passes++;
  endtask

  task automatic test_branch();
    load_nop();
    for (int i = 0; i < 4; i++) mem[32'h100 + i] = 8'($urandom);
    do_reset();
    step();
    step();
    branch_flag_i = 1'b1;
    branch_target_i = 32'h103;
    #1;
    checks++;
    if ({mem_req_o, if_valid_o} !== 2'b00)
      $display("FAIL branch_cyc: req=%b v=%b want 0 0",
               mem_req_o, if_valid_o);
    else passes++;
    step();
    branch_flag_i = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({if_valid_o, mem_req_o, mem_addr_o}
          !== {2'b01, 32'h100 + 32'(i)})
        $display("FAIL branch_issue %0d: v=%b req=%b addr=%h want 0 1 %h",
                 i, if_valid_o, mem_req_o, mem_addr_o, 32'h100 + i);
      else passes++;
      step();
    end
    checks++;
    if (if_valid_o !== 1'b0)
      $display("FAIL branch_early: v=%b want 0", if_valid_o);
    else passes++;
    step();
    checks++;
    if ({if_valid_o, if_pc_o, if_inst_o}
        !== {1'b1, 32'h100, word(32'h100)})
      $display("FAIL branch_done: v=%b pc=%h inst=%h want 1 100 %h",
               if_valid_o, if_pc_o, if_inst_o, word(32'h100));
    else passes++;
  endtask

  task automatic test_branch_stall();
    int n;
    logic [31:0] tgt;
    load_nop();
    tgt = 32'($urandom_range(32'h200, 32'hF00));
    do_reset();
    for (int c = 0; c < 5; c++) step();
    stall_i = 1'b1;
    branch_flag_i = 1'b1;
    branch_target_i = tgt;
    #1;
    checks++;
    if ({if_valid_o, mem_req_o} !== 2'b10)
      $display("FAIL brst_cyc: v=%b req=%b want 1 0",
               if_valid_o, mem_req_o);
    else passes++;
    step();
    branch_flag_i = 1'b0;
    #1;
    checks++;
    if ({if_valid_o, mem_req_o, mem_addr_o}
        !== {2'b01, tgt & ~32'h3})
      $display("FAIL brst_next: v=%b req=%b addr=%h want 0 1 %h",
               if_valid_o, mem_req_o, mem_addr_o, tgt & ~32'h3);
    else passes++;
    stall_i = 1'b0;
    wait_valid(20, n);
    checks++;
    if ({if_valid_o, if_pc_o, if_inst_o}
        !== {1'b1, tgt & ~32'h3, word(tgt & ~32'h3)})
      $display("FAIL brst_done: v=%b pc=%h inst=%h want 1 %h %h",
               if_valid_o, if_pc_o, if_inst_o,
               tgt & ~32'h3, word(tgt & ~32'h3));
    else passes++;
  endtask

  task automatic test_reset_mid();
    int n;
    load_nop();
    do_reset();
    branch_flag_i = 1'b1;
    branch_target_i = 32'h40;
    step();
    branch_flag_i = 1'b0;
    #1;
    wait_valid(20, n);
    checks++;
    if ({if_valid_o, if_pc_o} !== {1'b1, 32'h40})
      $display("FAIL rmid_pre: v=%b pc=%h want 1 40", if_valid_o, if_pc_o);
    else passes++;
    step();
    step();
    step();
    rst = 1'b0;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o} !== 98'b0)
      $display("FAIL rmid_zero: req=%b addr=%h v=%b pc=%h inst=%h want 0",
               mem_req_o, mem_addr_o, if_valid_o, if_pc_o, if_inst_o);
    else passes++;
    step();
    rst = 1'b1;
    #1;
    checks++;
    if ({mem_req_o, mem_addr_o} !== {1'b1, 32'h0})
      $display("FAIL rmid_restart: req=%b addr=%h want 1 0",
               mem_req_o, mem_addr_o);
    else passes++;
    wait_valid(20, n);
    checks++;
    if ({if_valid_o, if_pc_o, if_inst_o} !== {1'b1, 32'h0, 32'h13})
      $display("FAIL rmid_done: v=%b pc=%h inst=%h want 1 0 00000013",
               if_valid_o, if_pc_o, if_inst_o);
    else passes++;
  endtask

  // Model: a fetch needs four accepted byte requests; the instruction
  // appears two cycles after the fourth accept and leaves on a non-stall.
  task automatic test_random();
    logic [31:0] m_pc, tgt;
    int m_k, shown, errs;
    logic m_done, br, exp_req;
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    do_reset();
    m_pc = 32'h0;
    m_k = 0;
    m_done = 1'b0;
    shown = 0;
    errs = 0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      br = ($urandom_range(0, 40) == 0);
      tgt = 32'($urandom_range(0, 32'hFFF));
      mem_busy_i = ($urandom_range(0, 3) == 0);
      stall_i = ($urandom_range(0, 2) == 0);
      branch_flag_i = br;
      branch_target_i = tgt;
      #1;
      exp_req = !m_done && m_k < 4 && !br;
      checks++;
      if ({mem_req_o, if_valid_o} !== {exp_req, m_done}) begin
        errs++;
        if (errs < 10)
          $display("FAIL rnd_ctl cyc%0d: req=%b v=%b want %b %b",
                   cyc, mem_req_o, if_valid_o, exp_req, m_done);
      end else passes++;
      if (exp_req) begin
        checks++;
        if (mem_addr_o !== m_pc + 32'(m_k)) begin
          errs++;
          if (errs < 10)
            $display("FAIL rnd_addr cyc%0d: addr=%h want %h",
                     cyc, mem_addr_o, m_pc + 32'(m_k));
        end else passes++;
      end
      if (m_done) begin
        checks++;
        if ({if_pc_o, if_inst_o} !== {m_pc, word(m_pc)}) begin
          errs++;
          if (errs < 10)
            $display("FAIL rnd_inst cyc%0d: pc=%h inst=%h want %h %h",
                     cyc, if_pc_o, if_inst_o, m_pc, word(m_pc));
        end else passes++;
      end
      if (br) begin
        m_pc = tgt & ~32'h3;
        m_k = 0;
        m_done = 1'b0;
      end else if (m_done) begin
        if (!stall_i) begin
          m_pc = m_pc + 32'd4;
          m_k = 0;
          m_done = 1'b0;
          shown++;
        end
      end else if (m_k == 4) begin
        m_done = 1'b1;
      end else if (!mem_busy_i) begin
        m_k++;
      end
      step();
    end
    branch_flag_i = 1'b0;
    stall_i = 1'b0;
    mem_busy_i = 1'b0;
    checks++;
    if (shown < 50)
      $display("FAIL rnd_progress: shown=%0d want >= 50", shown);
    else passes++;
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 8'($urandom);
    test_reset();
    test_basic();
    test_busy();
    test_stall();
    test_branch();
    test_branch_stall();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
